// File: rtl/mul49_share_arbiter.sv
// Round-robin front end that time-shares one external pipelined multiplier among
// several requesters and tags each product with the owning requester's index.
module mul49_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int DIN_WIDTH   = 49,
    parameter int DOUT_WIDTH  = 98,
    parameter int MUL_LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [ID_WIDTH-1:0]            res_id,
    output logic [DOUT_WIDTH-1:0]          res_data,
    output logic                           mul_ce,
    output logic [DIN_WIDTH-1:0]           mul_din0,
    output logic [DIN_WIDTH-1:0]           mul_din1,
    input  logic [DOUT_WIDTH-1:0]          mul_dout,
    output logic                           busy
);

    logic [MUL_LATENCY-1:0] vld_sr_reg;
    logic [ID_WIDTH-1:0]    id_sr_reg [MUL_LATENCY];
    logic [ID_WIDTH-1:0]    rr_ptr_reg;

    logic                   advance;
    logic                   transfer;
    logic                   grant_found;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic [ID_WIDTH:0]      cand;

    logic [DIN_WIDTH-1:0]   a_arr [NUM_REQ];
    logic [DIN_WIDTH-1:0]   b_arr [NUM_REQ];

    assign advance = !res_valid || res_ready;
    assign mul_ce  = advance;
    // Gating with reset_n keeps req_ready low while reset is held, even with requests pending.
    assign transfer = grant_found && advance && reset_n;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*DIN_WIDTH +: DIN_WIDTH];
            assign b_arr[gi]     = req_b[gi*DIN_WIDTH +: DIN_WIDTH];
            assign req_ready[gi] = transfer && (grant_idx == ID_WIDTH'(gi));
        end
    endgenerate

    // Search begins one past the last grant; cand is one bit wider so the wrap is explicit.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(k);
            if (cand >= (ID_WIDTH+1)'(NUM_REQ)) begin
                cand = cand - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_WIDTH-1:0];
            end
        end
    end

    assign mul_din0 = grant_found ? a_arr[grant_idx] : '0;
    assign mul_din1 = grant_found ? b_arr[grant_idx] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr_reg <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                id_sr_reg[i] <= '0;
            end
            rr_ptr_reg <= ID_WIDTH'(NUM_REQ - 1);
        end else if (advance) begin
            vld_sr_reg   <= {vld_sr_reg[MUL_LATENCY-2:0], transfer};
            id_sr_reg[0] <= grant_idx;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                id_sr_reg[i] <= id_sr_reg[i-1];
            end
            if (transfer) begin
                rr_ptr_reg <= grant_idx;
            end
        end
    end

    // Product data is never reset; the valid pipeline alone decides what is real.
    assign res_valid = vld_sr_reg[MUL_LATENCY-1];
    assign res_id    = id_sr_reg[MUL_LATENCY-1];
    assign res_data  = mul_dout;
    assign busy      = |vld_sr_reg;

endmodule

// File: tb/tb_mul49_share_arbiter.sv
// Bench for mul49_share_arbiter: models the external multiplier, checks every cycle
// against a queue-based reference, and runs vector table, corner sequences and random traffic.
module tb_mul49_share_arbiter;

    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int DW  = 49;
    localparam int OW  = 98;
    localparam int LAT = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_a = '0;
    logic [NR*DW-1:0]   req_b = '0;
    logic               res_valid;
    logic               res_ready = 1'b1;
    logic [IW-1:0]      res_id;
    logic [OW-1:0]      res_data;
    logic               mul_ce;
    logic [DW-1:0]      mul_din0;
    logic [DW-1:0]      mul_din1;
    logic [OW-1:0]      mul_dout;
    logic               busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul49_share_arbiter #(
        .NUM_REQ(NR), .ID_WIDTH(IW), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .MUL_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .busy(busy)
    );

    // External multiplier: LAT ce-enabled registers, no reset.
    logic [OW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= OW'(mul_din0) * OW'(mul_din1);
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_dout = mpipe[LAT-1];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: in-flight list, each entry counting advancing edges until it is presented.
    typedef struct {
        int          id;
        logic [OW-1:0] prod;
        int          rem;
    } flight_t;
    flight_t fq[$];
    int m_ptr = NR - 1;

    function automatic int m_grant();
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_res_valid();
        return (fq.size() > 0) && (fq[0].rem == 0);
    endfunction

    function automatic void m_reset();
        fq.delete();
        m_ptr = NR - 1;
    endfunction

    always @(posedge clk) begin
        int g;
        bit adv;
        flight_t f;
        if (!reset_n) begin
            m_reset();
        end else begin
            g   = m_grant();
            adv = !m_res_valid() || res_ready;
            if (adv) begin
                if (m_res_valid()) void'(fq.pop_front());
                foreach (fq[i]) if (fq[i].rem > 0) fq[i].rem--;
                if (g >= 0) begin
                    f.id   = g;
                    f.prod = OW'(req_a[g*DW +: DW]) * OW'(req_b[g*DW +: DW]);
                    f.rem  = LAT - 1;
                    fq.push_back(f);
                    m_ptr = g;
                end
            end
        end
    end

    always @(negedge clk) begin
        int g;
        bit ev, adv;
        logic [NR-1:0] er;
        logic [DW-1:0] ea, eb;
        ev  = m_res_valid();
        adv = !ev || res_ready;
        g   = m_grant();
        er  = '0;
        if (reset_n && adv && g >= 0) er[g] = 1'b1;
        ea = (g >= 0) ? req_a[g*DW +: DW] : '0;
        eb = (g >= 0) ? req_b[g*DW +: DW] : '0;
        chk("res_valid", res_valid, ev);
        chk("mul_ce", mul_ce, adv);
        chk("req_ready", req_ready, er);
        chk("mul_din0", mul_din0, ea);
        chk("mul_din1", mul_din1, eb);
        chk("busy", busy, fq.size() > 0);
        if (ev) begin
            chk("res_id", res_id, fq[0].id);
            chk("res_data", res_data, fq[0].prod);
        end
    end

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3 reset_n = 1'b0;
        m_reset();
        #1;
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mul_ce"}, mul_ce, 1);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    task automatic set_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
    endtask

    function automatic logic [DW-1:0] rand49();
        logic [DW-1:0] v;
        v = DW'({$urandom, $urandom});
        if ($urandom_range(0, 7) == 0) v = '1;
        return v;
    endfunction

    typedef struct {
        int            id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vt [5];
    logic [OW-1:0] got_d [$];
    int            got_i [$];

    initial begin
        int lat, sent;
        bit got;
        logic [OW-1:0] held_d;
        logic [IW-1:0] held_i;

        vt[0] = '{0, 49'd3, 49'd5, 98'd15};
        vt[1] = '{1, {DW{1'b1}}, {DW{1'b1}}, 98'h3_FFFF_FFFF_FFFC_0000_0000_0001};
        vt[2] = '{2, 49'd0, {DW{1'b1}}, 98'd0};
        vt[3] = '{3, 49'd123456789, 49'd987654321, 98'd121932631112635269};
        vt[4] = '{0, 49'h1_0000_0000_0000, 49'd2, 98'h2_0000_0000_0000};

        @(negedge clk);
        chk("init_res_valid", res_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_mul_ce", mul_ce, 1);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Table: one isolated op each, latency and product checked.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 req_valid = '0;
            req_valid[vt[i].id] = 1'b1;
            set_op(vt[i].id, vt[i].a, vt[i].b);
            @(negedge clk);
            chk("tbl_ready", req_ready, 4'(1) << vt[i].id);
            @(posedge clk);
            #1 req_valid = '0;
            lat = 0;
            got = 0;
            for (int n = 0; n < 20 && !got; n++) begin
                @(negedge clk);
                lat++;
                if (res_valid) got = 1;
            end
            chk("tbl_latency", lat, LAT);
            if (got) begin
                chk("tbl_id", res_id, vt[i].id);
                chk("tbl_data", res_data, vt[i].exp);
            end
        end

        // Round-robin with all four requesters continuously valid.
        do_reset("rr_rst");
        @(posedge clk);
        #1 req_valid = '1;
        for (int i = 0; i < NR; i++) set_op(i, DW'(i + 1), 49'd10);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) chk("rr_grant", req_ready, 4'(1) << (c % 4));
            if (c >= 4) begin
                chk("rr_res_valid", res_valid, 1);
                chk("rr_res_id", res_id, (c - 4) % 4);
                chk("rr_res_data", res_data, ((c - 4) % 4 + 1) * 10);
            end
            if (c == 7) begin
                @(posedge clk);
                #1 req_valid = '0;
            end
        end

        // Backpressure: 6 ops from req1, consumer stalls cycles 4..6.
        do_reset("bp_rst");
        sent = 0;
        got_d.delete();
        got_i.delete();
        held_d = '0;
        held_i = '0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1 res_ready = !(c >= 4 && c <= 6);
            req_valid = '0;
            req_valid[1] = (sent < 6);
            set_op(1, DW'(sent + 1), 49'd7);
            @(negedge clk);
            if (c == 4) begin
                held_d = res_data;
                held_i = res_id;
            end
            if (c >= 4 && c <= 6) begin
                chk("bp_mul_ce", mul_ce, 0);
                chk("bp_req_ready", req_ready, 0);
                chk("bp_hold_data", res_data, held_d);
                chk("bp_hold_id", res_id, held_i);
            end
            if (req_ready[1]) sent++;
            if (res_valid && res_ready) begin
                got_d.push_back(res_data);
                got_i.push_back(res_id);
            end
        end
        res_ready = 1'b1;
        req_valid = '0;
        chk("bp_count", got_d.size(), 6);
        for (int k = 0; k < got_d.size() && k < 6; k++) begin
            chk("bp_order_data", got_d[k], (k + 1) * 7);
            chk("bp_order_id", got_i[k], 1);
        end

        // Bubbles and pointer hold across idle cycles.
        do_reset("bub_rst");
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 case (c)
                0:       req_valid = 4'b0100;
                3, 4:    req_valid = 4'b1001;
                default: req_valid = 4'b0000;
            endcase
            for (int i = 0; i < NR; i++) set_op(i, DW'(i + 2), 49'd3);
            @(negedge clk);
            if (c == 0) chk("bub_grant2", req_ready, 4'b0100);
            if (c == 1 || c == 2) chk("bub_idle_res", res_valid, 0);
            if (c == 3) chk("bub_grant3", req_ready, 4'b1000);
            if (c == 4) chk("bub_grant0", req_ready, 4'b0001);
        end

        // Asynchronous reset with three products in flight.
        do_reset("mid_rst0");
        @(posedge clk);
        #1 req_valid = 4'b1110;
        for (int i = 0; i < NR; i++) set_op(i, DW'(i + 5), 49'd9);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 req_valid = '0;
        chk("mid_busy_before", busy, 1);
        #2 reset_n = 1'b0;
        m_reset();
        #1;
        chk("mid_res_valid", res_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_mul_ce", mul_ce, 1);
        chk("mid_res_id", res_id, 0);
        req_valid = 4'b0101;
        set_op(0, 49'd11, 49'd13);
        #1 chk("mid_ready_in_reset", req_ready, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        chk("mid_first_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        lat = 0;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            lat++;
            if (res_valid) got = 1;
        end
        chk("mid_latency", lat, LAT);
        if (got) begin
            chk("mid_id", res_id, 0);
            chk("mid_data", res_data, 143);
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1 req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) set_op(i, rand49(), rand49());
            res_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1 req_valid = '0;
        res_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("drain_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul49_share_arbiter.md
Name: mul49_share_arbiter

Overview:
- Shares one pipelined 49x49 unsigned multiplier (4-cycle latency, clock-enable stalled, no reset on its data registers) among NUM_REQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle.
- Carries the requester ID and a valid bit alongside the multiplier pipeline, and returns each product with its ID on a single result port.
- Result backpressure stalls the whole pipeline through the multiplier's ce.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_WIDTH, 2, requester index width; must equal clog2(NUM_REQ)
- DIN_WIDTH, 49, operand width
- DOUT_WIDTH, 98, product width (2*DIN_WIDTH)
- MUL_LATENCY, 4, ce-enabled edges from operand capture to valid multiplier dout

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*DIN_WIDTH  packed operand A; requester i at bits [i*DIN_WIDTH +: DIN_WIDTH]
- req_b  in  NUM_REQ*DIN_WIDTH  packed operand B; same packing as req_a
- res_valid  out  1  result valid
- res_ready  in  1  result consumer accept
- res_id  out  ID_WIDTH  index of the requester that owns res_data
- res_data  out  DOUT_WIDTH  product; wired straight from mul_dout
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  DIN_WIDTH  multiplier operand 0
- mul_din1  out  DIN_WIDTH  multiplier operand 1
- mul_dout  in  DOUT_WIDTH  multiplier product (registered inside the multiplier)
- busy  out  1  high while any stage of the valid pipeline is set

Behaviour:
- advance = !res_valid | res_ready. mul_ce = advance; this is combinational.
- Arbitration:
  - rr_ptr (ID_WIDTH bits) holds the index of the last granted requester.
  - The search starts at rr_ptr+1 mod NUM_REQ and grants the first index with req_valid set.
  - Grant logic is combinational.
- Issue:
  - req_ready[g] = advance & req_valid[g] for the granted index g; all other bits are 0.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - mul_din0/mul_din1 = req_a/req_b of the granted index. When no request is pending they are driven to zero.
- Tracking pipeline:
  - vld_sr and id_sr are MUL_LATENCY deep and shift only when advance=1.
  - Stage 0 captures (transfer occurred, g).
  - res_valid = vld_sr[last]; res_id = id_sr[last]; res_data = mul_dout.
- Latency:
  - A request accepted at edge t appears as res_valid at cycle t+MUL_LATENCY when there is no stall.
  - Throughput is 1 per cycle. Every stall cycle adds 1 cycle to all in-flight operations.
- rr_ptr updates to g only on a transfer. With no transfer it holds.
- Stall (res_valid & !res_ready):
  - mul_ce=0; all req_ready=0.
  - vld_sr, id_sr and rr_ptr all hold.
  - res_id and res_data stay stable until accepted.
- Bubbles: cycles with no transfer shift a 0 valid bit. The multiplier still clocks garbage through, which is never flagged valid.
- Ordering: results leave in issue order. No reordering and no dropping.
- Single requester: a continuously valid single requester is granted every advancing cycle.
- Requester may drop req_valid before acceptance. Operands are sampled only on a transfer.
- Reset (asserted, including mid-operation):
  - vld_sr=0, id_sr=0, rr_ptr=NUM_REQ-1 so that index 0 has first priority.
  - Outputs: res_valid=0, busy=0, req_ready=0, mul_ce=1, res_id=0.
  - In-flight products are discarded. Multiplier data registers are not reset and are masked by vld_sr.
- busy = OR of vld_sr.
- Operands are unsigned. The multiplier zero-extends, so full 49-bit values are legal.

Test Plan:
- Single op: after reset, req0 a=3, b=5 for one cycle -> req_ready[0]=1 that cycle; 4 cycles later res_valid=1, res_id=0, res_data=15.
- Round-robin: all four valid continuously, a=i+1, b=10, res_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles; results 10,20,30,40 appear with ids 0..3 back-to-back starting at cycle 4.
- Max width: a=b=2^49-1 -> res_data=2^98-2^50+1.
- Backpressure: stream of 6 ops from req1, res_ready low for 3 cycles when the first result appears -> mul_ce=0 and req_ready=0 for those 3 cycles; res_data/res_id held; all 6 results delivered in order with no loss or duplicate.
- Bubbles and pointer hold: req2 issues, 2 idle cycles, then req0 and req3 both valid -> req3 granted first (search starts after 2), then req0; 0-valid bubbles never raise res_valid.
- Reset mid-operation: 3 ops in flight, pulse reset_n low asynchronously between edges -> res_valid=0 and busy=0 immediately; no stale result after release; the next request from req0 is granted first and completes with correct latency.
